// File: rtl/bcd_ascii_tx.sv
// bcd_ascii_tx: prints an 8-bit value as ASCII decimal digits (optional CR/LF) on an 8N1 line.
module bcd_ascii_tx #(
  parameter int BAUD_DIV_0 = 5208,
  parameter int BAUD_DIV_1 = 2604,
  parameter int BAUD_DIV_2 = 868,
  parameter int BAUD_DIV_3 = 434,
  parameter int LZB = 1,
  parameter int CRLF = 1
) (
  input  logic       src_clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {S_IDLE, S_CONV, S_LOAD, S_START, S_DATA, S_STOP, S_FIN} state_t;
  state_t state_q, state_d;
  logic [19:0] sr_q;
  logic [1:0] sel_q;
  logic [2:0] nb_q, idx_q, e;
  logic [12:0] bc_q, div;
  logic [8:0] fr_q;
  logic tx_q, acc, bit_end, last;
  logic [3:0] h, t, o, t_adj, o_adj;
  logic [7:0] ch;
  assign h = sr_q[19:16];
  assign t = sr_q[15:12];
  assign o = sr_q[11:8];
  assign tx = tx_q;
  // hundreds never exceeds 2 while converting, so only tens and ones need the add-3
  assign t_adj = t >= 4'd5 ? t + 4'd3 : t;
  assign o_adj = o >= 4'd5 ? o + 4'd3 : o;
  always_comb begin
    div = sel_q == 2'd0 ? 13'(BAUD_DIV_0 - 1) :
          sel_q == 2'd1 ? 13'(BAUD_DIV_1 - 1) :
          sel_q == 2'd2 ? 13'(BAUD_DIV_2 - 1) : 13'(BAUD_DIV_3 - 1);
    acc = start && (state_q == S_IDLE || state_q == S_FIN);
    bit_end = bc_q == 13'd0;
    last = idx_q == (CRLF != 0 ? 3'd5 : 3'd3);
    e = idx_q;
    if (LZB != 0 && e == 3'd0 && h == 4'd0) e = 3'd1;
    if (LZB != 0 && e == 3'd1 && h == 4'd0 && t == 4'd0) e = 3'd2;
    ch = e == 3'd0 ? {4'h3, h} : e == 3'd1 ? {4'h3, t} : e == 3'd2 ? {4'h3, o} :
         e == 3'd3 ? 8'h0D : 8'h0A;
  end
  always_ff @(posedge src_clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: state_d = acc ? S_CONV : S_IDLE;
      S_CONV: state_d = nb_q == 3'd7 ? S_LOAD : S_CONV;
      S_LOAD: state_d = S_START;
      S_START: state_d = bit_end ? S_DATA : S_START;
      S_DATA: state_d = bit_end && nb_q == 3'd7 ? S_STOP : S_DATA;
      S_STOP: state_d = bit_end ? (last ? S_FIN : S_LOAD) : S_STOP;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != S_IDLE && state_q != S_FIN;
    done = state_q == S_FIN;
  end
  always_ff @(posedge src_clk or posedge rst)
    if (rst) begin
      sr_q <= '0;
      sel_q <= '0;
      nb_q <= '0;
      idx_q <= '0;
      bc_q <= '0;
      fr_q <= '0;
      tx_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_FIN:
          if (acc) begin
            sr_q <= {12'd0, data};
            sel_q <= baud_sel;
            nb_q <= '0;
            idx_q <= '0;
          end
        S_CONV: begin
          sr_q <= {h[2:0], t_adj, o_adj, sr_q[7:0], 1'b0};
          nb_q <= nb_q + 3'd1;
        end
        S_LOAD: begin
          fr_q <= {1'b1, ch};
          tx_q <= 1'b0;
          bc_q <= div;
          nb_q <= '0;
          idx_q <= e + 3'd1;
        end
        default:
          if (bit_end) begin
            tx_q <= fr_q[0];
            fr_q <= {1'b1, fr_q[8:1]};
            bc_q <= div;
            if (state_q == S_DATA) nb_q <= nb_q + 3'd1;
          end else bc_q <= bc_q - 13'd1;
      endcase
    end
endmodule

// File: tb/tb_bcd_ascii_tx.sv
// tb_bcd_ascii_tx: three parameter variants driven together, checked every cycle against a timeline model.
module tb_bcd_ascii_tx;
  localparam int DIVS[4] = '{4, 3, 5, 2};
  localparam int LZBS[3] = '{0, 1, 1};
  localparam int CRLFS[3] = '{1, 1, 0};
  logic src_clk, rst, start;
  logic [1:0] baud_sel;
  logic [7:0] data;
  logic [2:0] tx_w, busy_w, done_w;
  int checks = 0, failures = 0;
  int o[3], ml[3], dv[3], nc[3], dcnt[3];
  logic [7:0] chs[3][5];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bcd_ascii_tx #(.BAUD_DIV_0(DIVS[0]), .BAUD_DIV_1(DIVS[1]), .BAUD_DIV_2(DIVS[2]),
                   .BAUD_DIV_3(DIVS[3]), .LZB(LZBS[g]), .CRLF(CRLFS[g])) dut (
      .src_clk(src_clk), .rst(rst), .baud_sel(baud_sel), .start(start), .data(data),
      .tx(tx_w[g]), .busy(busy_w[g]), .done(done_w[g]));
  end
  initial begin
    src_clk = 0;
    forever #5 src_clk = ~src_clk;
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // message = list of characters derived arithmetically from the decimal value
  task automatic build(input int i, input int d, input int sel);
    int hh, tt, oo;
    hh = d / 100;
    tt = (d / 10) % 10;
    oo = d % 10;
    nc[i] = 0;
    if (LZBS[i] == 0 || hh != 0) begin chs[i][nc[i]] = 8'(8'h30 + hh); nc[i]++; end
    if (LZBS[i] == 0 || hh != 0 || tt != 0) begin chs[i][nc[i]] = 8'(8'h30 + tt); nc[i]++; end
    chs[i][nc[i]] = 8'(8'h30 + oo); nc[i]++;
    if (CRLFS[i] != 0) begin
      chs[i][nc[i]] = 8'h0D; nc[i]++;
      chs[i][nc[i]] = 8'h0A; nc[i]++;
    end
    dv[i] = DIVS[sel];
    ml[i] = 8 + nc[i] * (1 + 10 * dv[i]) + 1;
  endtask
  always @(posedge src_clk or posedge rst)
    for (int i = 0; i < 3; i++)
      if (rst) o[i] = 0;
      else if ((o[i] == 0 || o[i] == ml[i]) && start) begin
        build(i, int'(data), int'(baud_sel));
        o[i] = 1;
      end else if (o[i] != 0) o[i] = o[i] == ml[i] ? 0 : o[i] + 1;
  // expected {tx, busy, done} at offset o cycles after the accepting edge
  function automatic logic [2:0] expv(input int i);
    int r, c, p, b;
    if (o[i] == 0) return 3'b100;
    if (o[i] == ml[i]) return 3'b101;
    if (o[i] <= 8) return 3'b110;
    r = o[i] - 9;
    c = r / (1 + 10 * dv[i]);
    p = r % (1 + 10 * dv[i]);
    if (p == 0) return 3'b110;
    b = (p - 1) / dv[i];
    return {b == 0 ? 1'b0 : b == 9 ? 1'b1 : chs[i][c][b-1], 2'b10};
  endfunction
  always @(negedge src_clk)
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d_tx_busy_done", i), int'({tx_w[i], busy_w[i], done_w[i]}), int'(expv(i)));
      if (done_w[i]) dcnt[i]++;
    end
  task automatic send(input logic [7:0] d, input logic [1:0] s);
    start = 1;
    data = d;
    baud_sel = s;
    @(posedge src_clk);
    #1 start = 0;
  endtask
  task automatic wait_idle;
    int n = 0;
    while ((o[0] != 0 || o[1] != 0 || o[2] != 0) && n < 3000) begin
      @(posedge src_clk);
      #1 n++;
    end
    if (n >= 3000) chk("wait_idle_timeout", n, 0);
  endtask
  initial begin
    int d1, n;
    rst = 1; start = 0; data = 0; baud_sel = 0;
    repeat (3) @(posedge src_clk);
    #1 chk("reset_tx", int'(tx_w), 7);
    chk("reset_busy_done", int'({busy_w, done_w}), 0);
    rst = 0;
    send(8'h7B, 2'd0);
    chk("busy_k1", int'(busy_w[0]), 1);
    chk("model_7b_len", nc[0], 5);
    chk("model_7b_chars", int'({chs[0][0], chs[0][1], chs[0][2], chs[0][3]}), 32'h3132330D);
    chk("model_7b_lf", int'(chs[0][4]), 8'h0A);
    chk("model_7b_cycles", ml[0], 214);
    repeat (8) @(posedge src_clk);
    #1 chk("tx_high_load_k9", int'(tx_w[0]), 1);
    @(posedge src_clk);
    #1 chk("tx_low_k10", int'(tx_w[0]), 0);
    d1 = dcnt[0];
    wait_idle;
    chk("done_once_7b", dcnt[0] - d1, 1);
    send(8'h00, 2'd1);
    chk("model_00", nc[1] * 256 + int'(chs[1][0]), 3 * 256 + 8'h30);
    wait_idle;
    send(8'h05, 2'd2);
    chk("model_05", nc[1] * 256 + int'(chs[1][0]), 3 * 256 + 8'h35);
    repeat (20) @(posedge src_clk);
    #1 baud_sel = 2'd0;
    wait_idle;
    send(8'hFF, 2'd3);
    chk("model_ff", int'({chs[1][0], chs[1][1], chs[1][2]}), 24'h323535);
    chk("model_ff_cycles", ml[1], 114);
    wait_idle;
    send(8'h64, 2'd3);
    chk("model_64_crlf0", nc[2] * 2**24 + int'({chs[2][0], chs[2][1], chs[2][2]}), 3 * 2**24 + 24'h313030);
    wait_idle;
    d1 = dcnt[1];
    send(8'h7B, 2'd3);
    repeat (15) @(posedge src_clk);
    #1 start = 1; data = 8'h11; baud_sel = 2'd0;
    @(posedge src_clk);
    #1 start = 0;
    chk("model_ignore_start", int'(chs[1][0]), 8'h31);
    wait_idle;
    chk("done_once_ignored", dcnt[1] - d1, 1);
    send(8'h7B, 2'd0);
    n = 0;
    while (o[1] != 60 && n < 500) begin
      @(posedge src_clk);
      #1 n++;
    end
    chk("reach_tens_bit", o[1], 60);
    d1 = dcnt[1];
    #1 rst = 1;
    #1 chk("async_rst_tx", int'(tx_w), 7);
    chk("async_rst_busy", int'(busy_w), 0);
    repeat (2) @(posedge src_clk);
    #1 rst = 0;
    chk("no_done_on_abort", dcnt[1] - d1, 0);
    send(8'h09, 2'd0);
    chk("model_09", nc[1] * 256 + int'(chs[1][0]), 3 * 256 + 8'h39);
    d1 = dcnt[1];
    wait_idle;
    chk("done_after_rst", dcnt[1] - d1, 1);
    start = 1; data = 8'h05; baud_sel = 2'd3;
    repeat (150) @(posedge src_clk);
    #1 start = 0;
    wait_idle;
    repeat (3) @(posedge src_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
